// File: rtl/ap_mon_pkg.sv
// Shared types and helpers for the ap_ctrl_chain handshake monitor.
package ap_mon_pkg;

   localparam int unsigned SAT_W = 64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } ap_mon_state_t;

   typedef enum logic [2:0] {
      FLD_STARTS   = 3'd0,
      FLD_DONES    = 3'd1,
      FLD_BUSY     = 3'd2,
      FLD_STALL    = 3'd3,
      FLD_LAST_LAT = 3'd4,
      FLD_MIN_LAT  = 3'd5,
      FLD_MAX_LAT  = 3'd6,
      FLD_STATUS   = 3'd7
   } ap_mon_field_t;

   // Increment that sticks at the all-ones value of a width-bit counter.
   function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] val,
                                                input int unsigned      width);
      logic [SAT_W-1:0] max_val;
      max_val = {SAT_W{1'b1}} >> (SAT_W - width);
      return (val >= max_val) ? val : val + SAT_W'(1);
   endfunction

endpackage

// File: rtl/ap_chan_monitor.sv
// One monitored module: handshake FSM, saturating counters, latency stats,
// sticky protocol error and a combinational field selector.
module ap_chan_monitor
   import ap_mon_pkg::*;
#(
   parameter int unsigned CNT_W = 32,
   parameter int unsigned LAT_W = 24
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             count_en_i,
   input  logic             start_i,
   input  logic             ready_i,
   input  logic             done_i,
   input  logic             cont_i,
   input  logic [2:0]       rd_field_i,
   output logic [CNT_W-1:0] rd_val_c_o,
   output logic             err_o
);

   ap_mon_state_t    state_q;
   logic [CNT_W-1:0] starts_q, dones_q, busy_q, stall_q;
   logic [LAT_W-1:0] lat_q, last_q, min_q, max_q;
   logic             err_q;

   logic             is_idle_c, is_run_c, is_hold_c;
   logic             start_evt_c, rec_evt_c, busy_evt_c, err_evt_c;
   logic [LAT_W-1:0] rec_lat_c;
   ap_mon_field_t    fld_c;

   function automatic logic [CNT_W-1:0] inc_cnt(input logic [CNT_W-1:0] v);
      return CNT_W'(sat_inc(SAT_W'(v), CNT_W));
   endfunction

   function automatic logic [LAT_W-1:0] inc_lat(input logic [LAT_W-1:0] v);
      return LAT_W'(sat_inc(SAT_W'(v), LAT_W));
   endfunction

   assign is_idle_c = (state_q == IDLE);
   assign is_run_c  = (state_q == RUN);
   assign is_hold_c = (state_q == HOLD);

   // A start is accepted from IDLE, or back-to-back with done+continue in RUN.
   assign start_evt_c = (is_idle_c && start_i) || (is_run_c && done_i && cont_i && start_i);
   assign rec_evt_c   = (is_idle_c && start_i && done_i) || (is_run_c && done_i);
   assign rec_lat_c   = is_run_c ? inc_lat(lat_q) : '0;
   assign busy_evt_c  = is_run_c || (is_idle_c && start_i);
   assign err_evt_c   = (is_idle_c && !start_i && (done_i || ready_i)) || (is_hold_c && done_i);

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         starts_q <= '0;
         dones_q  <= '0;
         busy_q   <= '0;
         stall_q  <= '0;
         lat_q    <= '0;
         last_q   <= '0;
         min_q    <= '1;
         max_q    <= '0;
         err_q    <= 1'b0;
      end else if (count_en_i) begin
         if (start_evt_c) starts_q <= inc_cnt(starts_q);
         if (busy_evt_c)  busy_q   <= inc_cnt(busy_q);
         if (is_hold_c)   stall_q  <= inc_cnt(stall_q);
         if (err_evt_c)   err_q    <= 1'b1;

         if (rec_evt_c) begin
            dones_q <= inc_cnt(dones_q);
            last_q  <= rec_lat_c;
            if (rec_lat_c < min_q) min_q <= rec_lat_c;
            if (rec_lat_c > max_q) max_q <= rec_lat_c;
         end

         if (start_evt_c)   lat_q <= '0;
         else if (is_run_c) lat_q <= inc_lat(lat_q);

         case (state_q)
            IDLE:    if (start_i) state_q <= done_i ? (cont_i ? IDLE : HOLD) : RUN;
            RUN:     if (done_i)  state_q <= cont_i ? (start_i ? RUN : IDLE) : HOLD;
            HOLD:    if (cont_i)  state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign fld_c = ap_mon_field_t'(rd_field_i);

   always_comb begin
      rd_val_c_o = '0;
      case (fld_c)
         FLD_STARTS:   rd_val_c_o = starts_q;
         FLD_DONES:    rd_val_c_o = dones_q;
         FLD_BUSY:     rd_val_c_o = busy_q;
         FLD_STALL:    rd_val_c_o = stall_q;
         FLD_LAST_LAT: rd_val_c_o = CNT_W'(last_q);
         FLD_MIN_LAT:  rd_val_c_o = CNT_W'(min_q);
         FLD_MAX_LAT:  rd_val_c_o = CNT_W'(max_q);
         FLD_STATUS:   rd_val_c_o = CNT_W'({err_q, state_q});
         default:      rd_val_c_o = '0;
      endcase
   end

   assign err_o = err_q;

endmodule

// File: rtl/ap_ctrl_multi_monitor.sv
// Parallel ap_ctrl_chain handshake monitor: one channel per HLS module,
// global freeze on finish, and a registered module/field read port.
module ap_ctrl_multi_monitor
   import ap_mon_pkg::*;
#(
   parameter  int unsigned NUM_MODULES = 4,
   parameter  int unsigned CNT_W       = 32,
   parameter  int unsigned LAT_W       = 24,
   localparam int unsigned RD_W        = (NUM_MODULES > 1) ? $clog2(NUM_MODULES) : 1
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [NUM_MODULES-1:0] ap_start,
   input  logic [NUM_MODULES-1:0] ap_ready,
   input  logic [NUM_MODULES-1:0] ap_done,
   input  logic [NUM_MODULES-1:0] ap_continue,
   input  logic                   finish,
   input  logic [RD_W-1:0]        rd_mod,
   input  logic [2:0]             rd_field,
   output logic [CNT_W-1:0]       rd_data,
   output logic                   frozen,
   output logic [NUM_MODULES-1:0] protocol_err
);

   logic             frozen_q;
   logic [CNT_W-1:0] rd_data_q;
   logic [CNT_W-1:0] ch_val_c [NUM_MODULES];
   logic [CNT_W-1:0] rd_sel_c;

   for (genvar g = 0; g < NUM_MODULES; g++) begin : g_chan
      ap_chan_monitor #(
         .CNT_W (CNT_W),
         .LAT_W (LAT_W)
      ) u_chan (
         .clock      (clock),
         .reset      (reset),
         .count_en_i (!frozen_q),
         .start_i    (ap_start[g]),
         .ready_i    (ap_ready[g]),
         .done_i     (ap_done[g]),
         .cont_i     (ap_continue[g]),
         .rd_field_i (rd_field),
         .rd_val_c_o (ch_val_c[g]),
         .err_o      (protocol_err[g])
      );
   end

   // Unpopulated module selects fall through to zero.
   always_comb begin
      rd_sel_c = '0;
      for (int i = 0; i < NUM_MODULES; i++) begin
         if (rd_mod == RD_W'(i)) rd_sel_c = ch_val_c[i];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         frozen_q  <= 1'b0;
         rd_data_q <= '0;
      end else begin
         if (finish) frozen_q <= 1'b1;
         rd_data_q <= rd_sel_c;
      end
   end

   assign rd_data = rd_data_q;
   assign frozen  = frozen_q;

endmodule
